// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between multicycle_ctrl and the multi-cycle datapath and memories.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      i_instr;
  logic             i_imem_ready;
  logic             i_dmem_ready;
  logic             i_br_taken;
  logic             o_imem_req;
  logic             o_ir_wren;
  logic             o_dmem_req;
  logic             o_mem_wren;
  logic             o_pc_wren;
  logic             o_pc_sel;
  logic [1:0]       o_op1_sel;
  logic             o_op2_sel;
  logic [3:0]       o_alu_opcode;
  logic             o_br_unsign;
  logic             o_rd_wren;
  logic [1:0]       o_wb_sel;
  logic             o_retire;
  logic [CNT_W-1:0] o_instret;
  logic             o_illegal;
  logic             o_timeout;
  logic [2:0]       o_state;

  modport master (
    input  i_instr, i_imem_ready, i_dmem_ready, i_br_taken,
    output o_imem_req, o_ir_wren, o_dmem_req, o_mem_wren, o_pc_wren, o_pc_sel,
           o_op1_sel, o_op2_sel, o_alu_opcode, o_br_unsign, o_rd_wren, o_wb_sel,
           o_retire, o_instret, o_illegal, o_timeout, o_state
  );

  modport slave (
    output i_instr, i_imem_ready, i_dmem_ready, i_br_taken,
    input  o_imem_req, o_ir_wren, o_dmem_req, o_mem_wren, o_pc_wren, o_pc_sel,
           o_op1_sel, o_op2_sel, o_alu_opcode, o_br_unsign, o_rd_wren, o_wb_sel,
           o_retire, o_instret, o_illegal, o_timeout, o_state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I(+mul) control FSM: FETCH/DECODE/EXEC/MEM/WB with req/ready memory
// handshakes, multi-cycle mul, retire counter and sticky illegal/timeout traps.
module multicycle_ctrl #(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_MUL, K_ILLEGAL
  } kind_e;

  localparam logic [3:0]       MUL_LAST  = 4'(MUL_CYCLES - 1);
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  kind_e      kind;
  logic [3:0] dec_alu;
  logic [1:0] dec_op1;
  logic       dec_op2;
  logic       unused_instr_bits;

  logic       imem_req, ir_wren, dmem_req, mem_wren, pc_wren, pc_sel;
  logic [1:0] op1_sel, wb_sel;
  logic       op2_sel, br_unsign, rd_wren, retire;
  logic [3:0] alu_opcode;

  assign opcode            = bus.i_instr[6:0];
  assign funct3            = bus.i_instr[14:12];
  assign funct7            = bus.i_instr[31:25];
  assign unused_instr_bits = ^{bus.i_instr[24:15], bus.i_instr[11:7]};

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  arith_op = 4'b0010;
      3'b010:  arith_op = 4'b0011;
      3'b011:  arith_op = 4'b0100;
      3'b100:  arith_op = 4'b0101;
      3'b101:  arith_op = alt ? 4'b0111 : 4'b0110;
      3'b110:  arith_op = 4'b1000;
      default: arith_op = 4'b1001;
    endcase
  endfunction

  // Decode depends only on the IR, which stays stable from DECODE to retirement.
  always_comb begin
    kind    = K_ILLEGAL;
    dec_alu = 4'b0000;
    dec_op1 = 2'b00;
    dec_op2 = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000001) begin
          kind    = (funct3 == 3'b000) ? K_MUL : K_ILLEGAL;
          dec_alu = 4'b1010;
        end else begin
          kind    = K_ALU;
          dec_alu = arith_op(funct3, funct7[5]);
        end
      end
      7'b0010011: begin
        kind    = K_ALU;
        dec_op2 = 1'b1;
        dec_alu = arith_op(funct3, funct7[5] & (funct3 == 3'b101));
      end
      7'b0000011: begin kind = K_LOAD;   dec_op2 = 1'b1; end
      7'b0100011: begin kind = K_STORE;  dec_op2 = 1'b1; end
      7'b1100011: begin kind = K_BRANCH; dec_op1 = 2'b01; dec_op2 = 1'b1; end
      7'b1101111: begin kind = K_JUMP;   dec_op1 = 2'b01; dec_op2 = 1'b1; end
      7'b1100111: begin kind = K_JUMP;   dec_op2 = 1'b1; end
      7'b0110111: begin kind = K_ALU;    dec_op1 = 2'b10; dec_op2 = 1'b1; end
      7'b0010111: begin kind = K_ALU;    dec_op1 = 2'b01; dec_op2 = 1'b1; end
      default:    kind = K_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mul_cnt_d  = '0;
    wait_d     = '0;
    instret_d  = instret_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    imem_req   = 1'b0;
    ir_wren    = 1'b0;
    dmem_req   = 1'b0;
    mem_wren   = 1'b0;
    pc_wren    = 1'b0;
    pc_sel     = 1'b0;
    op1_sel    = 2'b00;
    op2_sel    = 1'b0;
    alu_opcode = 4'b0000;
    br_unsign  = 1'b0;
    rd_wren    = 1'b0;
    wb_sel     = 2'b00;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.i_imem_ready) begin
          ir_wren = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (kind == K_ILLEGAL) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        op1_sel    = dec_op1;
        op2_sel    = dec_op2;
        alu_opcode = dec_alu;
        case (kind)
          K_BRANCH: begin
            br_unsign = funct3[1];
            pc_wren   = 1'b1;
            pc_sel    = bus.i_br_taken;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          K_MUL: begin
            if (mul_cnt_q == MUL_LAST) state_d = S_WB;
            else                       mul_cnt_d = mul_cnt_q + 4'd1;
          end
          K_LOAD, K_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        mem_wren   = (kind == K_STORE);
        op1_sel    = dec_op1;
        op2_sel    = dec_op2;
        alu_opcode = dec_alu;
        if (bus.i_dmem_ready) begin
          if (kind == K_STORE) begin
            pc_wren = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rd_wren = 1'b1;
        pc_wren = 1'b1;
        retire  = 1'b1;
        pc_sel  = (kind == K_JUMP);
        wb_sel  = (kind == K_LOAD) ? 2'b01 : (kind == K_JUMP) ? 2'b10 : 2'b00;
        state_d = S_FETCH;
      end
      default: state_d = state_q;
    endcase

    if (retire) instret_d = instret_q + CNT_ONE;

    // Reset masks every side effect combinationally, so an in-flight access is dropped at once.
    if (!i_rst_n) begin
      imem_req = 1'b0;
      ir_wren  = 1'b0;
      dmem_req = 1'b0;
      mem_wren = 1'b0;
      pc_wren  = 1'b0;
      rd_wren  = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      mul_cnt_q <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_imem_req   = imem_req;
  assign bus.o_ir_wren    = ir_wren;
  assign bus.o_dmem_req   = dmem_req;
  assign bus.o_mem_wren   = mem_wren;
  assign bus.o_pc_wren    = pc_wren;
  assign bus.o_pc_sel     = pc_sel;
  assign bus.o_op1_sel    = op1_sel;
  assign bus.o_op2_sel    = op2_sel;
  assign bus.o_alu_opcode = alu_opcode;
  assign bus.o_br_unsign  = br_unsign;
  assign bus.o_rd_wren    = rd_wren;
  assign bus.o_wb_sel     = wb_sel;
  assign bus.o_retire     = retire;
  assign bus.o_instret    = instret_q;
  assign bus.o_illegal    = illegal_q;
  assign bus.o_timeout    = timeout_q;
  assign bus.o_state      = state_q;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle successor to the single-cycle RV32I(+mul) control unit. It is an FSM that sequences FETCH/DECODE/EXEC/MEM/WB over several clocks. Memories are reached through req/ready handshakes, and `mul` runs as a parametrised multi-cycle operation. It sits between the instruction register, PC, regfile, ALU and memory ports of the multi-cycle datapath, and also provides retire counting and sticky trap flags.

Parameters:
MUL_CYCLES, 4, cycles spent in EXEC for mul (legal range 1..15)
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before trapping (legal range 2..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_instr  in  32  instruction register contents; stable from DECODE through end of instruction
i_imem_ready  in  1  instruction memory data valid
i_dmem_ready  in  1  data memory access complete
i_br_taken  in  1  branch comparator result for current instruction
o_imem_req  out  1  instruction fetch request
o_ir_wren  out  1  load instruction register
o_dmem_req  out  1  data memory request
o_mem_wren  out  1  data memory write (store)
o_pc_wren  out  1  update PC
o_pc_sel  out  1  0 = pc+4, 1 = ALU result (jump/branch target)
o_op1_sel  out  2  00 = rs1, 01 = pc, 10 = zero
o_op2_sel  out  1  0 = rs2, 1 = imm
o_alu_opcode  out  4  add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001, mul 1010
o_br_unsign  out  1  unsigned branch compare
o_rd_wren  out  1  regfile write
o_wb_sel  out  2  00 = ALU, 01 = mem rdata, 10 = pc+4
o_retire  out  1  one-cycle pulse on instruction completion
o_instret  out  CNT_W  retired-instruction count
o_illegal  out  1  sticky: illegal opcode trapped
o_timeout  out  1  sticky: memory timeout trapped
o_state  out  3  FSM state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5

Behaviour:
- Reset: on an edge with i_rst_n=0, the FSM goes to FETCH and counters/flags clear (o_instret=0, o_illegal=0, o_timeout=0). While i_rst_n=0, all req/wren/retire outputs are forced 0. Reset wins over every other event, including mid-MEM (o_dmem_req is 0 during reset and the access is abandoned).
- Opcodes: R 0110011, I 0010011, load 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Any other opcode is illegal.
- FETCH:
  - o_imem_req=1.
  - On i_imem_ready=1: o_ir_wren=1 in that cycle, then DECODE.
- DECODE:
  - Illegal opcode -> TRAP, setting o_illegal.
  - Otherwise -> EXEC. No side effects.
- EXEC: ALU controls are valid.
  - R-type: funct3 plus bit30 select the op; funct7=0000001 with funct3=000 is mul. Other funct7=0000001 encodings are illegal (trap from DECODE).
  - I-type: bit30 is consulted only for srai/srli; addi ignores bit30.
  - Load/store/JALR: add, op1=rs1, op2=imm.
  - JAL/AUIPC/branch target: add, op1=pc, op2=imm.
  - LUI: add, op1=zero, op2=imm.
  - Branch: o_br_unsign=funct3[1]; o_pc_wren=1 and o_pc_sel=i_br_taken; retire; then FETCH.
  - mul: stays in EXEC for exactly MUL_CYCLES cycles (internal counter; controls held), then WB.
  - Load/store -> MEM; all others -> WB.
- MEM:
  - o_dmem_req=1, o_mem_wren=1 for stores; ALU controls held.
  - On i_dmem_ready: a store pulses o_pc_wren (pc+4), retires, then FETCH; a load goes to WB.
- WB:
  - o_rd_wren=1, o_pc_wren=1, retire, then FETCH.
  - o_wb_sel: 01 for load, 10 for JAL/JALR (o_pc_sel=1), 00 otherwise.
- Retire: o_retire is high in the same cycle as the retiring o_pc_wren. o_instret increments on that edge and wraps at 2^CNT_W.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and counts cycles with ready low.
  - If ready is still low on the MEM_TIMEOUT-th cycle -> TRAP, setting o_timeout.
  - Ready in that same cycle takes priority (no trap).
- TRAP: all enables and requests 0, flags held. Exits only via reset.
- Outputs that are don't-care in a state are driven 0.

Test Plan:
- `add x3,x1,x2` (0x002081B3) with ready always 1 -> states 0,1,2,4,0; o_alu_opcode=0000; o_rd_wren and o_retire high in the WB cycle; o_instret 0->1.
- `lw` (0x0000A183), i_dmem_ready delayed 3 cycles -> MEM lasts 4 cycles with o_dmem_req held; WB o_wb_sel=01; 8 cycles total from FETCH.
- `mul` (0x022081B3), MUL_CYCLES=4 -> EXEC lasts exactly 4 cycles with o_alu_opcode=1010, then WB.
- `bltu` taken (0x0020E463, i_br_taken=1) -> EXEC: o_br_unsign=1, o_pc_sel=1, o_pc_wren=1, o_rd_wren=0; back to FETCH after 3 cycles.
- Fetch of opcode 0x7F -> TRAP; o_illegal=1 held. i_imem_ready low for 16 cycles with MEM_TIMEOUT=16 -> TRAP with o_timeout=1; ready arriving on cycle 16 -> no trap.
- Reset pulse while in MEM on a store -> o_dmem_req and o_mem_wren are 0 during reset; state=0 and o_instret=0 afterwards; o_imem_req=1 in the first cycle after release.
